// File: rtl/s9234_n161_bist.sv
// LFSR/MISR BIST controller for the s9234 n161 cone. N_PAT+1 cycles from start to the done pulse.
// No backpressure: start is taken only in IDLE, and abort returns the controller to IDLE.
module s9234_n161_bist #(
    parameter int                PAT_W  = 82,
    parameter int                SIG_W  = 16,
    parameter int                N_PAT  = 1024,
    parameter logic [PAT_W-1:0]  SEED   = {{(PAT_W-1){1'b0}}, 1'b1},
    parameter logic [SIG_W-1:0]  GOLDEN = '0
) (
    input  logic             CK,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pat,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(N_PAT - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic [PAT_W-1:0] pat_step;
    logic [SIG_W-1:0] sig_step;

    always_comb begin
        pat_step = {pat_q[PAT_W-2:0], pat_q[PAT_W-1] ^ pat_q[37] ^ pat_q[34]};
        sig_step = {sig_q[SIG_W-2:0],
                    sig_q[SIG_W-1] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3] ^ resp};
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    pat_d   = SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                // An aborted run keeps the signature of the patterns already compacted.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sig_d = sig_step;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                        pass_d  = (sig_step == GOLDEN);
                    end else begin
                        pat_d = pat_step;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign pat       = pat_q;
    assign signature = sig_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign pass      = pass_q;

endmodule

// File: tb/tb_s9234_n161_bist.sv
// Directed bench for s9234_n161_bist: three instances cover N_PAT=4, N_PAT=1 and a
// full 1024-pattern run driven by a stand-in cone model.
module tb_s9234_n161_bist;

    logic CK = 1'b0;
    logic rst_n;
    always #5 CK = ~CK;

    // N_PAT=4 instance
    logic        start_4, abort_4, resp_4;
    logic [81:0] pat_4;
    logic        busy_4, done_4, pass_4;
    logic [15:0] sig_4;

    // N_PAT=1 instance
    logic        start_1, abort_1, resp_1;
    logic [81:0] pat_1;
    logic        busy_1, done_1, pass_1;
    logic [15:0] sig_1;

    // N_PAT=1024 instance, resp from the cone model
    logic        start_k, abort_k, resp_k;
    logic [81:0] pat_k;
    logic        busy_k, done_k, pass_k;
    logic [15:0] sig_k;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt_k = 0;

    s9234_n161_bist #(.N_PAT(4), .GOLDEN(16'h0000)) u_d4 (
        .CK(CK), .rst_n(rst_n), .start(start_4), .abort(abort_4), .pat(pat_4),
        .resp(resp_4), .busy(busy_4), .done(done_4), .pass(pass_4), .signature(sig_4));

    s9234_n161_bist #(.N_PAT(1)) u_d1 (
        .CK(CK), .rst_n(rst_n), .start(start_1), .abort(abort_1), .pat(pat_1),
        .resp(resp_1), .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1));

    s9234_n161_bist #(.N_PAT(1024)) u_dk (
        .CK(CK), .rst_n(rst_n), .start(start_k), .abort(abort_k), .pat(pat_k),
        .resp(resp_k), .busy(busy_k), .done(done_k), .pass(pass_k), .signature(sig_k));

    // Stand-in combinational cone: parity of a masked subset plus a few AND/OR terms.
    function automatic logic cone(input logic [81:0] p);
        logic [81:0] mask;
        mask = 82'h2A50F3C9D1766B481E3;
        return (^(p & mask)) ^ (p[5] & p[60]) ^ (p[77] | (p[12] & p[40]));
    endfunction

    function automatic logic [81:0] lfsr_m(input logic [81:0] p);
        return {p[80:0], p[81] ^ p[37] ^ p[34]};
    endfunction

    function automatic logic [15:0] misr_m(input logic [15:0] s, input logic r);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3] ^ r};
    endfunction

    assign resp_k = cone(pat_k);

    always @(negedge CK) if (done_k) done_cnt_k = done_cnt_k + 1;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [81:0] patm;
    logic [15:0] sigm;
    logic [15:0] sig_full;
    int          dc_before;

    initial begin
        rst_n = 1'b0;
        start_4 = 0; abort_4 = 0; resp_4 = 0;
        start_1 = 0; abort_1 = 0; resp_1 = 1;
        start_k = 0; abort_k = 0;
        tick(); tick();

        // reset state
        chk("rst_pat", pat_4, 82'h1);
        chk("rst_sig", sig_4, 82'h0);
        chk("rst_busy", busy_4, 82'h0);
        chk("rst_done", done_4, 82'h0);
        chk("rst_pass", pass_4, 82'h0);
        rst_n = 1'b1;
        tick();

        // N_PAT=4, resp=0: pattern walk 1,2,4,8 and pass
        start_4 = 1; tick(); start_4 = 0;
        chk("z_pat0", pat_4, 82'h1);
        chk("z_busy", busy_4, 82'h1);
        tick(); chk("z_pat1", pat_4, 82'h2);
        tick(); chk("z_pat2", pat_4, 82'h4);
        tick(); chk("z_pat3", pat_4, 82'h8);
        chk("z_nodone", done_4, 82'h0);
        tick();
        chk("z_done", done_4, 82'h1);
        chk("z_sig", sig_4, 82'h0);
        chk("z_pass", pass_4, 82'h1);
        chk("z_pathold", pat_4, 82'h8);
        tick();
        chk("z_done_off", done_4, 82'h0);
        chk("z_idle", busy_4, 82'h0);
        chk("z_passhold", pass_4, 82'h1);

        // N_PAT=4, resp=1: signature 000F, no pass; pass cleared at start
        resp_4 = 1;
        start_4 = 1; tick(); start_4 = 0;
        chk("o_passclr", pass_4, 82'h0);
        chk("o_sigclr", sig_4, 82'h0);
        tick(); tick(); tick(); tick();
        chk("o_done", done_4, 82'h1);
        chk("o_sig", sig_4, 82'h000F);
        chk("o_pass", pass_4, 82'h0);
        tick();

        // start with abort in IDLE: abort wins, signature held
        start_4 = 1; abort_4 = 1; tick(); start_4 = 0; abort_4 = 0;
        chk("sa_busy", busy_4, 82'h0);
        tick();
        chk("sa_busy2", busy_4, 82'h0);
        chk("sa_sighold", sig_4, 82'h000F);

        // N_PAT=1: done right after edge 1
        start_1 = 1; tick(); start_1 = 0;
        chk("n1_busy", busy_1, 82'h1);
        chk("n1_nodone", done_1, 82'h0);
        tick();
        chk("n1_done", done_1, 82'h1);
        chk("n1_sig", sig_1, 82'h1);
        tick();
        chk("n1_idle", busy_1, 82'h0);

        // N_PAT=1024: abort while pattern 10 is applied
        patm = 82'h1; sigm = 16'h0;
        dc_before = done_cnt_k;
        start_k = 1; tick(); start_k = 0;
        for (int i = 0; i < 10; i++) begin
            sigm = misr_m(sigm, cone(patm));
            patm = lfsr_m(patm);
            tick();
        end
        chk("ab_pat10", pat_k, patm);
        chk("ab_sig_pre", sig_k, sigm);
        abort_k = 1; tick(); abort_k = 0;
        chk("ab_busy", busy_k, 82'h0);
        chk("ab_sig", sig_k, sigm);
        chk("ab_pass", pass_k, 82'h0);
        tick(); tick();
        chk("ab_nodone", 82'(done_cnt_k - dc_before), 82'h0);

        // full uninterrupted run with start pulses ignored mid-run
        patm = 82'h1; sigm = 16'h0;
        for (int i = 0; i < 1024; i++) begin
            sigm = misr_m(sigm, cone(patm));
            patm = lfsr_m(patm);
        end
        sig_full = sigm;
        start_k = 1; tick(); start_k = 0;
        for (int i = 0; i < 1023; i++) begin
            start_k = (i == 100 || i == 700);
            tick();
        end
        start_k = 0;
        chk("fr_nodone", done_k, 82'h0);
        chk("fr_busy", busy_k, 82'h1);
        tick();
        chk("fr_done", done_k, 82'h1);
        chk("fr_sig", sig_k, sig_full);
        chk("fr_pass", pass_k, 82'(sig_full == 16'h0));
        tick();
        chk("fr_done_off", done_k, 82'h0);

        // reset at pattern 500, then a fresh run
        start_k = 1; tick(); start_k = 0;
        for (int i = 0; i < 500; i++) tick();
        rst_n = 1'b0; start_k = 1; tick(); start_k = 0; rst_n = 1'b1;
        chk("mr_busy", busy_k, 82'h0);
        chk("mr_pat", pat_k, 82'h1);
        chk("mr_sig", sig_k, 82'h0);
        start_k = 1; tick(); start_k = 0;
        for (int i = 0; i < 1023; i++) begin
            start_k = (i == 500);
            tick();
        end
        start_k = 0;
        tick();
        chk("mr_done", done_k, 82'h1);
        chk("mr_sig_full", sig_k, sig_full);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
